alu_result_ser: RTL and testbench
=================================

# alu_result_ser

Parallel-in, serial-out transmitter that drains a registered WIDTH-bit ALU result onto a single-wire frame. It sits downstream of the result pipeline register of the 4-bit ALU example. It accepts one word per valid/ready handshake and shifts it out as start bit, data bits LSB first, optional parity, and stop bit. It is the sending end of the result link; the link's receiver lives in the bench.

## Interface
Parameters:
- WIDTH, 8: data word width; minimum 1.
- CLKS_PER_BIT, 1: clk cycles per serial bit; minimum 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  word to transmit; sampled only on handshake.
- din_valid  input  1  upstream has a word.
- din_ready  output  1  block can accept; equals (state == IDLE).
- ser_out  output  1  serial line; registered; idles high.
- ser_busy  output  1  high from the cycle after acceptance through the last STOP cycle.
- frame_done  output  1  one-cycle pulse in the last clk cycle of STOP.

## Operation
- Five states: IDLE, START, DATA, PARITY, STOP.
- PARITY exists only when ALU_SER_PARITY_EN is defined.
- IDLE:
  - ser_out=1, din_ready=1.
  - On din_valid && din_ready: latch din into the shift register, clear the bit counter, go to START.
- START: ser_out=0 for one bit period, then go to DATA.
- DATA:
  - ser_out = shift register bit 0.
  - At each bit-period end, shift right and increment the bit counter.
  - After bit WIDTH-1, go to PARITY (if compiled in) or STOP.
- PARITY: ser_out = XOR of the latched word (even parity) for one bit period, then go to STOP.
- STOP: ser_out=1 for one bit period, with frame_done pulsed in its final cycle, then go to IDLE.
- din and din_valid are ignored outside IDLE. A word held valid during a frame is accepted on the first IDLE cycle.
- Bit counter width is $clog2(WIDTH+1). The bit-period counter is $clog2(CLKS_PER_BIT+1) bits wide and wraps 0..CLKS_PER_BIT-1.
- Reset asserted mid-frame: the frame is aborted immediately (asynchronous) and the block behaves as after a power-up reset.

## Timing
- Reset values: state=IDLE, ser_out=1, din_ready=1, ser_busy=0, frame_done=0, counters=0.
- Handshake in cycle N: ser_out=0 from cycle N+1, because ser_out is registered and updates on the same edge as the state.
- Frame length F = (2 + WIDTH + P) x CLKS_PER_BIT cycles, with P=1 when parity is enabled, else 0.
  - WIDTH=8, no parity, CLKS_PER_BIT=1: F=10.
- frame_done is asserted in cycle N+F. din_ready returns high in cycle N+F+1.
- Back-to-back frames therefore have exactly one idle-high cycle between STOP and the next START.
- ser_busy rises in N+1 and falls in N+F+1.
- din_ready is combinational from state only; it never depends on din_valid.

## Configuration
- Macro: ALU_SER_PARITY_EN.
- Defined: the PARITY state is present, P=1, and F includes one parity bit period.
- Undefined: PARITY state and parity logic are absent, and DATA goes directly to STOP. Port list is identical in both builds.

## Structure
- Shared package alu_ser_pkg holds:
  - the state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - the line levels LINE_IDLE=1 and START_BIT=0;
  - a function returning frame bits (2 + WIDTH + P) for use by the bench.
- Sub-module alu_ser_bit_tick: bit-period counter.
  - Inputs: clk, rst_n, clear.
  - Output: tick, high in the last cycle of each bit period.
  - Instanced once.
- The FSM and shift register stay in alu_result_ser.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release -> ser_out=1, din_ready=1, ser_busy=0, frame_done=0.
- Single frame, no parity, CLKS_PER_BIT=1, din=8'hA5 -> ser_out over 10 cycles = 0,1,0,1,0,0,1,0,1,1; frame_done in cycle 10.
- Parity build, din=8'h01 -> parity bit 1, frame 11 cycles. Parity build, din=8'hA5 -> parity bit 0.
- CLKS_PER_BIT=4, din=8'hFF held valid continuously -> each bit lasts 4 cycles, F=40; second word accepted in cycle N+41; one idle-high cycle between frames.
- din_valid toggled mid-frame with changing din -> transmitted bits unchanged; din_ready stays 0 until IDLE.
- rst_n pulsed low during DATA bit 3 -> ser_out=1 immediately, state IDLE; a new frame after release is transmitted correctly.

Source files
------------

// File: rtl/alu_ser_pkg.sv
// ============================================================================
// Module      : alu_ser_pkg
// Description : Shared types, line levels and frame-length helper for the
//               ALU result serial link. Optional feature: ALU_SER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef ALU_SER_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } ser_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

`ifdef ALU_SER_PARITY_EN
    localparam int c_parity_bits = 1;
`else
    localparam int c_parity_bits = 0;
`endif

    // Serial bit periods per frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int width);
        return 2 + width + c_parity_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ser_bit_tick.sv
// ============================================================================
// Module      : alu_ser_bit_tick
// Description : Bit-period counter; tick marks the last clk of each period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ser_bit_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int                c_cnt_w = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_at_last;

    assign w_at_last = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Held in clear while idle so the first period after a start is full length.
    assign tick = !clear && w_at_last;

endmodule

`default_nettype wire

// File: rtl/alu_result_ser.sv
// ============================================================================
// Module      : alu_result_ser
// Description : Valid/ready parallel-in, serial-out frame transmitter for the
//               ALU result word. Optional feature: ALU_SER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_ser
    import alu_ser_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_busy,
    output logic             frame_done
);

    localparam int                    c_bit_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_bit_cnt_w-1:0] c_last_bit  = c_bit_cnt_w'(WIDTH - 1);

    ser_state_t             r_state;
    ser_state_t             w_state_next;
    logic [WIDTH-1:0]       r_shift;
    logic [WIDTH-1:0]       w_shift_next;
    logic [c_bit_cnt_w-1:0] r_bit_cnt;
    logic [c_bit_cnt_w-1:0] w_bit_cnt_next;
    logic                   r_ser_out;
    logic                   w_ser_next;
    logic                   w_tick;
    logic                   w_idle;
    logic                   w_accept;
`ifdef ALU_SER_PARITY_EN
    logic                   r_parity;
    logic                   w_parity_next;
`endif

    assign w_idle   = (r_state == IDLE);
    assign w_accept = din_valid && w_idle;

    alu_ser_bit_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_idle),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
`ifdef ALU_SER_PARITY_EN
        w_parity_next  = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_next   = din;
                    w_bit_cnt_next = '0;
`ifdef ALU_SER_PARITY_EN
                    w_parity_next  = ^din;
`endif
                    w_state_next   = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = r_bit_cnt + c_bit_cnt_w'(1);
                    if (r_bit_cnt == c_last_bit) begin
`ifdef ALU_SER_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
`ifdef ALU_SER_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The line level is derived from the next state so ser_out changes on the
    // same edge as the state it belongs to.
    always_comb begin
        w_ser_next = LINE_IDLE;
        case (w_state_next)
            START:   w_ser_next = START_BIT;
            DATA:    w_ser_next = w_shift_next[0];
`ifdef ALU_SER_PARITY_EN
            PARITY:  w_ser_next = w_parity_next;
`endif
            default: w_ser_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_ser_out <= LINE_IDLE;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_ser_out <= w_ser_next;
        end
    end

`ifdef ALU_SER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_next;
        end
    end
`endif

    assign din_ready  = w_idle;
    assign ser_out    = r_ser_out;
    assign ser_busy   = !w_idle;
    assign frame_done = (r_state == STOP) && w_tick;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_ser.sv
// ============================================================================
// Module      : tb_alu_result_ser
// Description : Self-checking bench for alu_result_ser (CLKS_PER_BIT 1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_ser;

    localparam int W  = 8;
    localparam int FB = alu_ser_pkg::frame_bits(W);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din        [2];
    logic       din_valid  [2];
    logic       din_ready  [2];
    logic       ser_out    [2];
    logic       ser_busy   [2];
    logic       frame_done [2];

    int n_cmp  = 0;
    int n_fail = 0;

    // Line model: one expected frame per instance, indexed by elapsed cycles.
    bit          active [2];
    int          el     [2];
    logic [15:0] fv     [2];

    always #5 clk = ~clk;

    alu_result_ser #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .ser_out(ser_out[0]),
        .ser_busy(ser_busy[0]), .frame_done(frame_done[0])
    );

    alu_result_ser #(.WIDTH(W), .CLKS_PER_BIT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .ser_out(ser_out[1]),
        .ser_busy(ser_busy[1]), .frame_done(frame_done[1])
    );

    function automatic int cpb_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Frame bit k (in transmit order) lives at index k.
    function automatic logic [15:0] make_frame(input logic [7:0] w);
        logic [15:0] f;
        f = '0;
        f[0] = 1'b0;
        for (int b = 0; b < W; b++) f[1 + b] = w[b];
`ifdef ALU_SER_PARITY_EN
        f[1 + W] = ^w;
`endif
        f[FB - 1] = 1'b1;
        return f;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int   span;
        logic idle;
        logic e_ser;
        logic e_done;
        for (int i = 0; i < 2; i++) begin
            span = FB * cpb_of(i);
            if (rst_n !== 1'b1) active[i] = 1'b0;
            idle = !active[i];
            if (idle) begin
                e_ser  = 1'b1;
                e_done = 1'b0;
            end else begin
                e_ser  = fv[i][el[i] / cpb_of(i)];
                e_done = (el[i] == span - 1);
            end
            chk($sformatf("u%0d.ser_out", i),    ser_out[i],    e_ser);
            chk($sformatf("u%0d.ser_busy", i),   ser_busy[i],   !idle);
            chk($sformatf("u%0d.din_ready", i),  din_ready[i],  idle);
            chk($sformatf("u%0d.frame_done", i), frame_done[i], e_done);
            if (!idle) begin
                el[i]++;
                if (el[i] == span) active[i] = 1'b0;
            end else if (rst_n === 1'b1 && din_valid[i] === 1'b1) begin
                active[i] = 1'b1;
                el[i]     = 0;
                fv[i]     = make_frame(din[i]);
            end
        end
    end

    task automatic send(input int i, input logic [7:0] w);
        int t;
        @(posedge clk);
        #1;
        din[i]       = w;
        din_valid[i] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (din_ready[i] !== 1'b1 && t < 200);
        chk("send_ready_seen", din_ready[i], 1'b1);
        @(posedge clk);
        #1;
        din_valid[i] = 1'b0;
    endtask

    // Hand-written line sequences on instance 0 (MSB of exp = first bit).
    task automatic lit_frame(input logic [7:0] w, input logic [15:0] exp, input int n);
        send(0, w);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("lit_ser", ser_out[0], exp[n - 1 - k]);
            chk("lit_done", frame_done[0], (k == n - 1));
        end
    endtask

    initial begin
        int t;
        int cnt;
        rst_n        = 1'b0;
        din[0]       = 8'h00;
        din[1]       = 8'h00;
        din_valid[0] = 1'b0;
        din_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ser_out",    ser_out[0],    1'b1);
        chk("rst_din_ready",  din_ready[0],  1'b1);
        chk("rst_ser_busy",   ser_busy[0],   1'b0);
        chk("rst_frame_done", frame_done[0], 1'b0);

`ifdef ALU_SER_PARITY_EN
        lit_frame(8'hA5, 16'b01010010101, 11);
        lit_frame(8'h01, 16'b01000000011, 11);
`else
        lit_frame(8'hA5, 16'b0101001011, 10);
        lit_frame(8'h01, 16'b0100000001, 10);
`endif

        // Input churn while busy must not disturb the frame in flight.
        send(0, 8'h3C);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            din[0]       = 8'($urandom);
            din_valid[0] = k[0];
            chk("busy_ready_low", din_ready[0], 1'b0);
        end
        din_valid[0] = 1'b0;
        repeat (6) @(posedge clk);

        // Abort during data bit 3; reset must act without a clock edge.
        send(0, 8'h96);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ser_out",   ser_out[0],   1'b1);
        chk("abort_din_ready", din_ready[0], 1'b1);
        chk("abort_ser_busy",  ser_busy[0],  1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef ALU_SER_PARITY_EN
        lit_frame(8'hA5, 16'b01010010101, 11);
`else
        lit_frame(8'hA5, 16'b0101001011, 10);
`endif

        // Slow instance, word held valid across two frames.
        @(posedge clk);
        #1;
        din[1]       = 8'hFF;
        din_valid[1] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (din_ready[1] === 1'b1 && t < 50);
        cnt = 0;
        while (din_ready[1] === 1'b0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk_int("slow_busy_cycles", cnt, FB * 4);
        chk("slow_gap_ser_out", ser_out[1],   1'b1);
        chk("slow_gap_ready",   din_ready[1], 1'b1);
        @(negedge clk);
        chk("slow_second_ready", din_ready[1], 1'b0);
        chk("slow_second_start", ser_out[1],   1'b0);
        @(posedge clk);
        #1;
        din_valid[1] = 1'b0;
        repeat (FB * 4 + 4) @(posedge clk);

        send(1, 8'h5A);
        repeat (FB * 4 + 4) @(posedge clk);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
